// File: rtl/bram_tile_requester.sv
// Purpose: sequences one tile command at a time into the tile BRAM manager and returns read tiles.
// Latency: read accept-to-response = manager valid delay + 1 (3 cycles for a 2-edge manager); write 1 cycle, wr_done 1 cycle later.
// Backpressure: cmd_ready only in IDLE; a held response (rsp_ready low) blocks new commands indefinitely.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake; cmd_op/line/col/tile carry the command
//   rsp_valid/rsp_ready              read response handshake; rsp_op/err/tile carry the result
//   wr_done                          one-cycle pulse the cycle after an O write
//   ena_q/k/v/o, wea_o               manager port enables and O write enable
//   sel_line, sel_col, mat_w         manager address selects and write matrix
//   vld_q/k/v/o, mat_q/k/v/o         manager per-port valids and tiles
module bram_tile_requester #(
   parameter int TIMEOUT_CYC = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_op,
   input  logic [5:0]               cmd_line,
   input  logic [2:0]               cmd_col,
   input  logic [0:15][0:15][15:0]  cmd_tile,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [2:0]               rsp_op,
   output logic                     rsp_err,
   output logic [0:15][0:15][15:0]  rsp_tile,
   output logic                     wr_done,
   output logic                     ena_q,
   output logic                     ena_k,
   output logic                     ena_v,
   output logic                     ena_o,
   output logic                     wea_o,
   output logic [5:0]               sel_line,
   output logic [2:0]               sel_col,
   output logic [0:15][0:15][15:0]  mat_w,
   input  logic                     vld_q,
   input  logic                     vld_k,
   input  logic                     vld_v,
   input  logic                     vld_o,
   input  logic [0:15][0:15][15:0]  mat_q,
   input  logic [0:15][0:15][15:0]  mat_k,
   input  logic [0:15][0:15][15:0]  mat_v,
   input  logic [0:15][0:15][15:0]  mat_o
);

   typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t                    state, state_nxt;
   logic [7:0]                cnt;
   logic                      sel_vld;
   logic [0:15][0:15][15:0]   sel_mat;
   logic                      timeout_hit;

   // Only the port addressed by the latched op is observed; the others are ignored.
   always_comb begin
      sel_vld = 1'b0;
      sel_mat = '0;
      case (rsp_op[1:0])
         2'd0: begin sel_vld = vld_q; sel_mat = mat_q; end
         2'd1: begin sel_vld = vld_k; sel_mat = mat_k; end
         2'd2: begin sel_vld = vld_v; sel_mat = mat_v; end
         default: begin sel_vld = vld_o; sel_mat = mat_o; end
      endcase
   end

   // cnt counts completed RD cycles; this edge is the TIMEOUT_CYC-th one.
   assign timeout_hit = (cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Enables are decoded straight from state so an async reset drops them at once.
   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      ena_q     = 1'b0;
      ena_k     = 1'b0;
      ena_v     = 1'b0;
      ena_o     = 1'b0;
      wea_o     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_op <= 3'd3)      state_nxt = RD;
               else if (cmd_op == 3'd4) state_nxt = WR;
               else                     state_nxt = RSP;
            end
         end
         RD: begin
            ena_q = (rsp_op[1:0] == 2'd0);
            ena_k = (rsp_op[1:0] == 2'd1);
            ena_v = (rsp_op[1:0] == 2'd2);
            ena_o = (rsp_op[1:0] == 2'd3);
            if (sel_vld || timeout_hit) state_nxt = RSP;
         end
         WR: begin
            ena_o     = 1'b1;
            wea_o     = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         sel_line <= '0;
         sel_col  <= '0;
         rsp_op   <= '0;
         rsp_err  <= 1'b0;
         rsp_tile <= '0;
         mat_w    <= '0;
         wr_done  <= 1'b0;
      end else begin
         wr_done <= (state == WR);
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  sel_line <= cmd_line;
                  sel_col  <= cmd_col;
                  rsp_op   <= cmd_op;
                  cnt      <= '0;
                  if (cmd_op == 3'd4) mat_w <= cmd_tile;
                  if (cmd_op > 3'd4) begin
                     rsp_err  <= 1'b1;
                     rsp_tile <= '0;
                  end
               end
            end
            RD: begin
               // Valid beats timeout when both land on the same edge.
               if (sel_vld) begin
                  rsp_tile <= sel_mat;
                  rsp_err  <= 1'b0;
               end else if (timeout_hit) begin
                  rsp_tile <= '0;
                  rsp_err  <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_tile_requester.sv
module tb_bram_tile_requester;

   typedef logic [0:15][0:15][15:0] tile_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, wr_done;
   logic [2:0] cmd_op, rsp_op, cmd_col, sel_col;
   logic [5:0] cmd_line, sel_line;
   tile_t      cmd_tile, rsp_tile, mat_w, mat_q, mat_k, mat_v, mat_o;
   logic       ena_q, ena_k, ena_v, ena_o, wea_o;
   logic       vld_q, vld_k, vld_v, vld_o;
   logic       mute_v;

   int checks = 0;
   int failures = 0;

   bram_tile_requester #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_line(cmd_line), .cmd_col(cmd_col), .cmd_tile(cmd_tile),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_err(rsp_err), .rsp_tile(rsp_tile), .wr_done(wr_done),
      .ena_q(ena_q), .ena_k(ena_k), .ena_v(ena_v), .ena_o(ena_o), .wea_o(wea_o),
      .sel_line(sel_line), .sel_col(sel_col), .mat_w(mat_w),
      .vld_q(vld_q), .vld_k(vld_k), .vld_v(vld_v), .vld_o(vld_o),
      .mat_q(mat_q), .mat_k(mat_k), .mat_v(mat_v), .mat_o(mat_o)
   );

   always #5 clk = ~clk;

   // Manager model: valid rises 2 edges after enable goes high; O port is a real memory.
   function automatic tile_t pat(input logic [1:0] p, input logic [5:0] l, input logic [2:0] c);
      tile_t t;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            t[i][j] = 16'(i * 16 + j) ^ {p, l, c, 5'd0};
      return t;
   endfunction

   int    mc_q = 0, mc_k = 0, mc_v = 0, mc_o = 0;
   tile_t o_mem [0:511];

   always @(posedge clk) begin
      mc_q <= ena_q ? ((mc_q >= 2) ? 2 : mc_q + 1) : 0;
      mc_k <= ena_k ? ((mc_k >= 2) ? 2 : mc_k + 1) : 0;
      mc_v <= ena_v ? ((mc_v >= 2) ? 2 : mc_v + 1) : 0;
      mc_o <= (ena_o && !wea_o) ? ((mc_o >= 2) ? 2 : mc_o + 1) : 0;
      if (ena_o && wea_o) o_mem[{sel_line, sel_col}] <= mat_w;
   end

   assign vld_q = (mc_q >= 2);
   assign vld_k = (mc_k >= 2);
   assign vld_v = (mc_v >= 2) && !mute_v;
   assign vld_o = (mc_o >= 2);
   assign mat_q = pat(2'd0, sel_line, sel_col);
   assign mat_k = pat(2'd1, sel_line, sel_col);
   assign mat_v = pat(2'd2, sel_line, sel_col);
   assign mat_o = o_mem[{sel_line, sel_col}];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ena_of(input logic [2:0] op);
      case (op)
         3'd0:    return ena_q;
         3'd1:    return ena_k;
         3'd2:    return ena_v;
         default: return ena_o;
      endcase
   endfunction

   // Issues a read, measures accept-to-response latency and enable cycles,
   // optionally holds rsp_ready low for 'hold' cycles, then completes the handshake.
   task automatic do_read(input string tag, input logic [2:0] op, input logic [5:0] l,
                          input logic [2:0] c, input tile_t exp_t, input logic exp_err,
                          input int exp_lat, input int hold);
      int n = 0;
      int enac = 0;
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_line = l; cmd_col = c;
      tick();
      cmd_valid = 1'b0;
      while (!rsp_valid && n < 40) begin
         if (ena_of(op)) enac++;
         tick();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_ena_cycles"}, 32'(enac), 32'(exp_lat));
      chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, "_op"}, 32'(rsp_op), 32'(op));
      chk({tag, "_tile_eq"}, 32'(rsp_tile === exp_t), 32'd1);
      chk({tag, "_no_ena"}, 32'({ena_q, ena_k, ena_v, ena_o}), 32'd0);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
         chk({tag, "_hold_tile"}, 32'(rsp_tile === exp_t), 32'd1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
   endtask

   tile_t wt;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_line = '0; cmd_col = '0;
      cmd_tile = '0; rsp_ready = 1'b0; mute_v = 1'b0;
      #3;
      chk("rst_ena", 32'({ena_q, ena_k, ena_v, ena_o, wea_o}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_err, wr_done}), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_sel", 32'({sel_line, sel_col, rsp_op}), 32'd0);
      chk("rst_tiles", 32'((rsp_tile === '0) && (mat_w === '0)), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // RD_K line 5 col 3, checked cycle by cycle
      cmd_valid = 1'b1; cmd_op = 3'd1; cmd_line = 6'd5; cmd_col = 3'd3;
      tick();
      cmd_valid = 1'b0;
      chk("rdk_sel", 32'({sel_line, sel_col}), 32'({6'd5, 3'd3}));
      for (int cy = 1; cy <= 3; cy++) begin
         chk("rdk_ena", 32'({ena_q, ena_k, ena_v, ena_o, wea_o}), 32'b01000);
         chk("rdk_wait", 32'({rsp_valid, cmd_ready}), 32'd0);
         tick();
      end
      chk("rdk_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rdk_ena_off", 32'(ena_k), 32'd0);
      chk("rdk_err", 32'(rsp_err), 32'd0);
      chk("rdk_tile_eq", 32'(rsp_tile === pat(2'd1, 6'd5, 3'd3)), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rdk_ready_again", 32'(cmd_ready), 32'd1);

      // WR_O line 63 col 7
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            wt[i][j] = 16'(i * 16 + j);
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_line = 6'd63; cmd_col = 3'd7; cmd_tile = wt;
      tick();
      cmd_valid = 1'b0; cmd_tile = '0;
      chk("wr_ena", 32'({ena_q, ena_k, ena_v, ena_o, wea_o}), 32'b00011);
      chk("wr_mat", 32'(mat_w === wt), 32'd1);
      chk("wr_done_early", 32'(wr_done), 32'd0);
      chk("wr_busy", 32'({cmd_ready, rsp_valid}), 32'd0);
      tick();
      chk("wr_ena_off", 32'({ena_o, wea_o}), 32'd0);
      chk("wr_done_pulse", 32'(wr_done), 32'd1);
      chk("wr_ready", 32'({cmd_ready, rsp_valid}), 32'b10);
      tick();
      chk("wr_done_clear", 32'(wr_done), 32'd0);

      do_read("rdo", 3'd3, 6'd63, 3'd7, wt, 1'b0, 3, 0);

      // RD_V with silent manager -> timeout after 8 cycles
      mute_v = 1'b1;
      do_read("tmo", 3'd2, 6'd10, 3'd1, '0, 1'b1, 8, 0);
      mute_v = 1'b0;

      // Illegal op 6
      cmd_valid = 1'b1; cmd_op = 3'd6; cmd_line = 6'd9; cmd_col = 3'd2;
      tick();
      cmd_valid = 1'b0;
      chk("ill_ena0", 32'({ena_q, ena_k, ena_v, ena_o, wea_o}), 32'd0);
      chk("ill_valid0", 32'(rsp_valid), 32'd1);
      tick();
      chk("ill_ena1", 32'({ena_q, ena_k, ena_v, ena_o, wea_o}), 32'd0);
      chk("ill_rsp", 32'({rsp_valid, rsp_err, rsp_op}), 32'({1'b1, 1'b1, 3'd6}));
      chk("ill_tile_zero", 32'(rsp_tile === '0), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Held response then back-to-back read
      do_read("rdq_hold", 3'd0, 6'd1, 3'd2, pat(2'd0, 6'd1, 3'd2), 1'b0, 3, 5);
      do_read("rdq_b2b", 3'd0, 6'd2, 3'd4, pat(2'd0, 6'd2, 3'd4), 1'b0, 3, 0);

      // Reset during RD cycle 2
      cmd_valid = 1'b1; cmd_op = 3'd0; cmd_line = 6'd7; cmd_col = 3'd6;
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("mid_ena_before", 32'(ena_q), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ena", 32'({ena_q, ena_k, ena_v, ena_o, wea_o}), 32'd0);
      chk("mid_rst_valid", 32'({rsp_valid, wr_done}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
      do_read("rdq_after_rst", 3'd0, 6'd33, 3'd5, pat(2'd0, 6'd33, 3'd5), 1'b0, 3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bram_tile_requester.md
# bram_tile_requester

Initiator-side sequencer for the attention datapath's tile BRAM manager. It accepts one tile command at a time (read Q/K/V/O tile, or write O tile) and drives the manager's enable/write-enable/select lines. For reads it waits for the manager's per-port valid, captures the 16x16 tile and returns it over a valid/ready response channel. It sits between the MHA control FSM / compute array and the BRAM manager.

## Interface
- TIMEOUT_CYC, 8: max cycles in RD waiting for port valid before error response; legal range 3..255.
- I_CLK  in  1  clock
- I_RST_N  in  1  reset, asynchronous, active-low
- I_CMD_VALID  in  1  command valid
- O_CMD_READY  out  1  command accepted when high with I_CMD_VALID
- I_CMD_OP  in  3  0=RD_Q, 1=RD_K, 2=RD_V, 3=RD_O, 4=WR_O, 5..7 illegal
- I_CMD_LINE  in  6  tile line 0..63
- I_CMD_COL  in  3  tile column 0..7
- I_CMD_TILE  in  [15:0][0:15][0:15]  write tile (WR_O only)
- O_RSP_VALID  out  1  read response valid
- I_RSP_READY  in  1  response consumed
- O_RSP_OP  out  3  op code of the response
- O_RSP_ERR  out  1  1 = timeout or illegal op
- O_RSP_TILE  out  [15:0][0:15][0:15]  captured tile
- O_WR_DONE  out  1  one-cycle pulse after an O write
- O_ENA_Q / O_ENA_K / O_ENA_V / O_ENA_O  out  1 each  manager port enables
- O_WEA_O  out  1  manager O write enable
- O_SEL_LINE  out  6  to all four manager line selects
- O_SEL_COL  out  3  to all four manager column selects
- O_MAT_W  out  [15:0][0:15][0:15]  to manager write matrix
- I_VLD_Q / I_VLD_K / I_VLD_V / I_VLD_O  in  1 each  manager port valids
- I_MAT_Q / I_MAT_K / I_MAT_V / I_MAT_O  in  [15:0][0:15][0:15]  manager tiles

## Operation
- States: IDLE, RD, WR, RSP. O_CMD_READY = (state==IDLE).
- IDLE, accept: register LINE/COL into O_SEL_*, op into O_RSP_OP; ops 0..3 -> RD (timeout counter cleared); op 4 -> WR with I_CMD_TILE registered into O_MAT_W; ops 5..7 -> RSP with err=1, tile all zero.
- RD: exactly one O_ENA_x high (x by op), O_WEA_O=0, SEL held. On edge where selected I_VLD_x=1: capture I_MAT_x into O_RSP_TILE, err=0, -> RSP. Other ports' valids ignored. Counter increments each RD cycle; if it reaches TIMEOUT_CYC without valid: tile zero, err=1, -> RSP.
- WR: O_ENA_O=1, O_WEA_O=1 for exactly one cycle, -> IDLE; O_WR_DONE=1 the following cycle. No response-channel transaction for writes.
- RSP: O_RSP_VALID=1, all enables 0; OP/ERR/TILE stable until I_RSP_READY=1, then -> IDLE.
- All enables 0 outside RD/WR (lets manager clear its internal toggle counter between requests).
- SEL and O_MAT_W hold last values in IDLE.

## Timing
- Reset (async assert, sync-to-clock deassert behaviour not required): state IDLE; all O_ENA_*, O_WEA_O, O_RSP_VALID, O_RSP_ERR, O_WR_DONE = 0; O_SEL_*, O_RSP_OP, O_RSP_TILE, O_MAT_W = 0; counter 0. Reset mid-RD/WR drops enables immediately; in-flight command lost, no response.
- Read with manager's 2-edge valid: accept at edge E0; ENA high cycles 1-3; valid seen at E3; O_RSP_VALID high from E3. Accept-to-response = 3 cycles.
- Write: accept at E0, ENA_O&WEA_O during cycle 1 (write at E1), O_WR_DONE during cycle 2, O_CMD_READY high again from E1.
- Illegal op: O_RSP_VALID high from E0+1 edge.
- Response same-cycle ready: accepted at that edge; O_CMD_READY high the next cycle (no command accept during RSP).
- Valid and timeout on same edge: valid wins, err=0.

## Test plan
- Reset, then RD_K line 5 col 3, manager model valid 2 edges after ENA -> O_ENA_K high 3 cycles, O_SEL={5,3}, O_RSP_VALID at accept+3, tile matches model, err=0.
- WR_O line 63 col 7 with tile[i][j]=i*16+j -> single-cycle ENA_O=WEA_O=1, O_MAT_W matches, O_WR_DONE pulse next cycle; follow with RD_O same address -> identical tile returned.
- RD_V with model never asserting valid, TIMEOUT_CYC=8 -> ENA_V drops after 8 cycles, rsp err=1, tile zero.
- I_CMD_OP=6 -> immediate response err=1, no enable ever asserted.
- RD_Q with I_RSP_READY low 5 cycles -> response stable 5 cycles, O_CMD_READY=0 throughout, back-to-back RD_Q accepted after handshake.
- Assert I_RST_N=0 during RD cycle 2 -> all enables and valids 0 asynchronously; after release, new RD_Q completes normally.
